// File: rtl/ddr_axi_pattern_sequencer_if.sv
// AXI4 master port bundle between the pattern sequencer and the MIG DDR3 slave.
interface ddr_axi_pattern_sequencer_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 512
);
    // write address channel
    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    // write data channel
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    // write response channel
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // read address channel
    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    // read data channel
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ddr_axi_pattern_sequencer.sv
// Write-then-verify DDR pattern sequencer: fills a region with an address-derived
// pattern one burst at a time, reads it back and reports error count / first bad address.
module ddr_axi_pattern_sequencer #(
    parameter int C_S_AXI_ID_WIDTH = 4,
    parameter int DATA_WIDTH       = 512,
    parameter int BURST_LEN        = 16
) (
    input  logic        sys_clk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_bursts,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    ddr_axi_pattern_sequencer_if.master m_axi
);
    localparam int          BEAT_BYTES = DATA_WIDTH / 8;
    localparam int          BEAT_LG    = $clog2(BEAT_BYTES);
    localparam int          WORDS      = DATA_WIDTH / 32;
    localparam int          SPAN_LG    = $clog2(BURST_LEN * BEAT_BYTES);
    localparam logic [31:0] SPAN       = 32'(BURST_LEN * BEAT_BYTES);
    localparam logic [31:0] BASE_MASK  = ~((32'd1 << SPAN_LG) - 32'd1);
    localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] seed_q, seed_d;
    logic [15:0] num_q, num_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] burst_addr_q, burst_addr_d;
    logic [8:0]  beat_q, beat_d;
    logic [15:0] err_q, err_d;
    logic [31:0] first_q, first_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        pend_q, pend_d;

    logic                  accept;
    logic                  last_beat;
    logic                  more_bursts;
    logic [16:0]           next_cnt;
    logic [31:0]           beat_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  w_hs, b_hs, r_hs;
    logic                  b_err, r_err;
    logic [15:0]           start_num;

    // A start seen in DONE is held in pend_q and taken on the following IDLE cycle.
    assign accept      = (state_q == S_IDLE) && (start || pend_q);
    assign start_num   = start ? num_bursts : num_q;
    assign last_beat   = (beat_q == LAST_BEAT);
    assign next_cnt    = {1'b0, burst_cnt_q} + 17'd1;
    assign more_bursts = (next_cnt < {1'b0, num_q});
    assign beat_addr   = burst_addr_q + (32'(beat_q) << BEAT_LG);
    assign w_hs        = (state_q == S_WR_DATA) && m_axi.wready;
    assign b_hs        = (state_q == S_WR_RESP) && m_axi.bvalid;
    assign r_hs        = (state_q == S_RD_DATA) && m_axi.rvalid;
    assign b_err       = b_hs && (m_axi.bresp != 2'b00);
    assign r_err       = r_hs && ((m_axi.rdata != exp_data) || (m_axi.rresp != 2'b00) ||
                                  (m_axi.rlast != last_beat));

    // Expected beat contents: word i = seed + beat address + 4*i; feeds both W and R compare.
    always_comb begin
        exp_data = '0;
        for (int i = 0; i < WORDS; i++)
            exp_data[i*32 +: 32] = seed_q + beat_addr + 32'(4 * i);
    end

    // State register.
    always_ff @(posedge sys_clk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: one burst in flight, all writes finish before any read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = (start_num == 16'd0) ? S_DONE : S_WR_ADDR;
            S_WR_ADDR: if (m_axi.awready) state_d = S_WR_DATA;
            S_WR_DATA: if (w_hs && last_beat) state_d = S_WR_RESP;
            S_WR_RESP: if (b_hs) state_d = more_bursts ? S_WR_ADDR : S_RD_ADDR;
            S_RD_ADDR: if (m_axi.arready) state_d = S_RD_DATA;
            S_RD_DATA: if (r_hs && last_beat) state_d = more_bursts ? S_RD_ADDR : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // AXI outputs decoded from state; payload comes from registers so it is stable while stalled.
    always_comb begin
        m_axi.awid    = {C_S_AXI_ID_WIDTH{1'b0}};
        m_axi.awaddr  = burst_addr_q;
        m_axi.awlen   = 8'(BURST_LEN - 1);
        m_axi.awsize  = 3'b110;
        m_axi.awburst = 2'b01;
        m_axi.awcache = 4'b0011;
        m_axi.awprot  = 3'b000;
        m_axi.awvalid = (state_q == S_WR_ADDR);
        m_axi.wdata   = exp_data;
        m_axi.wstrb   = '1;
        m_axi.wlast   = last_beat;
        m_axi.wvalid  = (state_q == S_WR_DATA);
        m_axi.bready  = (state_q == S_WR_RESP);
        m_axi.arid    = {C_S_AXI_ID_WIDTH{1'b0}};
        m_axi.araddr  = burst_addr_q;
        m_axi.arlen   = 8'(BURST_LEN - 1);
        m_axi.arsize  = 3'b110;
        m_axi.arburst = 2'b01;
        m_axi.arcache = 4'b0011;
        m_axi.arprot  = 3'b000;
        m_axi.arvalid = (state_q == S_RD_ADDR);
        m_axi.rready  = (state_q == S_RD_DATA);
    end

    // Run bookkeeping: latched config, burst/beat position, error accounting, status.
    always_comb begin
        base_d       = base_q;
        seed_d       = seed_q;
        num_d        = num_q;
        burst_cnt_d  = burst_cnt_q;
        burst_addr_d = burst_addr_q;
        beat_d       = beat_q;
        err_d        = err_q;
        first_d      = first_q;
        done_d       = done_q;
        pass_d       = pass_q;
        pend_d       = pend_q;

        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            base_d = base_addr & BASE_MASK;
            seed_d = seed;
            num_d  = num_bursts;
        end

        case (state_q)
            S_IDLE: if (accept) begin
                burst_addr_d = start ? (base_addr & BASE_MASK) : base_q;
                burst_cnt_d  = 16'd0;
                beat_d       = 9'd0;
                err_d        = 16'd0;
                first_d      = 32'd0;
                done_d       = 1'b0;
                pass_d       = 1'b0;
                pend_d       = 1'b0;
            end
            S_WR_DATA: if (w_hs) beat_d = last_beat ? 9'd0 : beat_q + 9'd1;
            // After the last write response, rewind to the region start for the verify pass.
            S_WR_RESP: if (b_hs) begin
                burst_cnt_d  = more_bursts ? next_cnt[15:0] : 16'd0;
                burst_addr_d = more_bursts ? burst_addr_q + SPAN : base_q;
            end
            S_RD_DATA: if (r_hs) begin
                beat_d = last_beat ? 9'd0 : beat_q + 9'd1;
                if (last_beat) begin
                    burst_cnt_d  = next_cnt[15:0];
                    burst_addr_d = burst_addr_q + SPAN;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = (err_q == 16'd0);
                if (start) pend_d = 1'b1;
            end
            default: ;
        endcase

        // At most one error event per cycle; the count saturates and the first address sticks.
        if ((b_err || r_err) && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
            if (err_q == 16'd0) first_d = b_err ? burst_addr_q : beat_addr;
        end
    end

    // busy tracks the state the FSM is about to enter.
    always_comb begin
        busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    end

    // Datapath registers.
    always_ff @(posedge sys_clk or negedge aresetn) begin
        if (!aresetn) begin
            base_q       <= '0;
            seed_q       <= '0;
            num_q        <= '0;
            burst_cnt_q  <= '0;
            burst_addr_q <= '0;
            beat_q       <= '0;
            err_q        <= '0;
            first_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            base_q       <= base_d;
            seed_q       <= seed_d;
            num_q        <= num_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_addr_q <= burst_addr_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            first_q      <= first_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            pend_q       <= pend_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
endmodule

// File: tb/tb_ddr_axi_pattern_sequencer.sv
// Bench for ddr_axi_pattern_sequencer: memory-backed AXI slave with optional stalls,
// write-response and read-beat error injection, driven by a table of runs plus hand sequences.
`timescale 1ns/1ps
module tb_ddr_axi_pattern_sequencer;
    logic        sys_clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    ddr_axi_pattern_sequencer_if #(.ID_W(4), .DATA_W(512)) axi ();

    ddr_axi_pattern_sequencer #(.C_S_AXI_ID_WIDTH(4), .DATA_WIDTH(512), .BURST_LEN(16)) dut (
        .sys_clk(sys_clk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .m_axi(axi.master)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] exp_base;
        logic [15:0] num;
        logic [31:0] seed;
        bit          stall;
        int          bresp_burst;
        int          cb0, cbt0, ck0;   // corrupt read: burst, beat, kind
        int          cb1, cbt1, ck1;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        bit          exp_pass;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    string tag = "";

    // slave configuration and observations
    logic [31:0] cfg_base = '0, cfg_seed = '0;
    bit          cfg_stall = 0;
    int          cfg_bresp = -1;
    int          c_burst[2] = '{-1, -1};
    int          c_beat[2]  = '{0, 0};
    int          c_kind[2]  = '{0, 0};
    int aw_cnt = 0, ar_cnt = 0, w_total = 0, w_bad = 0, addr_bad = 0, stab_bad = 0;
    logic [31:0] w_b3w0 = '0;
    logic [511:0] mem [logic [31:0]];

    logic [31:0] wr_addr = '0, rd_addr = '0;
    int  wr_beat = 0, rd_beat = 0, rd_burst = 0;
    bit  b_pend = 0, b_hs = 0, r_hs = 0, rd_active = 0;
    bit  p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
    logic [31:0]  p_awaddr = '0, p_araddr = '0;
    logic [511:0] p_wdata = '0;
    logic         p_wlast = 1'b0;

    function automatic logic [511:0] pat(input logic [31:0] s, input logic [31:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = s + a + 32'(4 * i);
        return d;
    endfunction

    function automatic bit rnd_or(input bit stall);
        return !stall || ($urandom_range(0, 1) == 1);
    endfunction

    // Slave: at each falling edge retire handshakes from the last rising edge, drive the
    // next cycle's ready/valid, then record handshakes the coming rising edge will complete.
    always @(negedge sys_clk) begin
        if (!aresetn) begin
            axi.awready = 0; axi.wready = 0; axi.arready = 0;
            axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0;
            axi.rlast = 0; axi.rdata = '0;
            b_pend = 0; b_hs = 0; r_hs = 0; rd_active = 0;
            p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
        end else begin
            if (p_awv && !p_awhs && (!axi.awvalid || axi.awaddr != p_awaddr)) stab_bad++;
            if (p_wv && !p_whs && (!axi.wvalid || axi.wdata != p_wdata || axi.wlast != p_wlast))
                stab_bad++;
            if (p_arv && !p_arhs && (!axi.arvalid || axi.araddr != p_araddr)) stab_bad++;

            if (b_hs) axi.bvalid = 0;
            if (r_hs) begin
                axi.rvalid = 0;
                rd_beat++;
                if (rd_beat == 16) rd_active = 0;
            end

            axi.awready = rnd_or(cfg_stall);
            axi.wready  = rnd_or(cfg_stall);
            axi.arready = rnd_or(cfg_stall);
            if (b_pend && !axi.bvalid && rnd_or(cfg_stall)) begin
                axi.bvalid = 1;
                axi.bresp  = (aw_cnt - 1 == cfg_bresp) ? 2'b10 : 2'b00;
                b_pend = 0;
            end
            if (rd_active && !axi.rvalid && rnd_or(cfg_stall)) begin
                logic [31:0]  a;
                logic [511:0] d;
                bit           flip;
                a = rd_addr + 32'(rd_beat) * 32'd64;
                d = mem.exists(a) ? mem[a] : '0;
                flip = 0;
                axi.rresp = 2'b00;
                for (int j = 0; j < 2; j++)
                    if (c_burst[j] == rd_burst && c_beat[j] == rd_beat) begin
                        if (c_kind[j] == 0 || c_kind[j] == 3) d[100] = ~d[100];
                        if (c_kind[j] == 1 || c_kind[j] == 3) axi.rresp = 2'b10;
                        if (c_kind[j] == 2 || c_kind[j] == 3) flip = 1;
                    end
                axi.rdata  = d;
                axi.rlast  = (rd_beat == 15) ^ flip;
                axi.rvalid = 1;
            end

            b_hs = axi.bvalid && axi.bready;
            r_hs = axi.rvalid && axi.rready;
            p_awv = axi.awvalid; p_awaddr = axi.awaddr; p_awhs = axi.awvalid && axi.awready;
            p_wv = axi.wvalid; p_wdata = axi.wdata; p_wlast = axi.wlast;
            p_whs = axi.wvalid && axi.wready;
            p_arv = axi.arvalid; p_araddr = axi.araddr; p_arhs = axi.arvalid && axi.arready;

            if (p_awhs) begin
                if (axi.awaddr != cfg_base + 32'(aw_cnt) * 32'd1024 || axi.awlen != 8'd15 ||
                    axi.awsize != 3'b110 || axi.awburst != 2'b01 || axi.awcache != 4'b0011 ||
                    axi.awprot != 3'b000 || axi.awid != 4'd0) addr_bad++;
                wr_addr = axi.awaddr;
                wr_beat = 0;
                aw_cnt++;
            end
            if (p_whs) begin
                logic [31:0] a;
                a = wr_addr + 32'(wr_beat) * 32'd64;
                if (axi.wdata != pat(cfg_seed, a) || axi.wstrb != {64{1'b1}} ||
                    axi.wlast != (wr_beat == 15)) w_bad++;
                if (aw_cnt == 1 && wr_beat == 3) w_b3w0 = axi.wdata[31:0];
                mem[a] = axi.wdata;
                wr_beat++;
                w_total++;
                if (wr_beat == 16) b_pend = 1;
            end
            if (p_arhs) begin
                if (axi.araddr != cfg_base + 32'(ar_cnt) * 32'd1024 || axi.arlen != 8'd15 ||
                    axi.arsize != 3'b110 || axi.arburst != 2'b01 || axi.arcache != 4'b0011 ||
                    axi.arprot != 3'b000 || axi.arid != 4'd0) addr_bad++;
                rd_addr = axi.araddr;
                rd_beat = 0;
                rd_burst = ar_cnt;
                rd_active = 1;
                ar_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic setup(input vec_t v);
        cfg_base = v.exp_base; cfg_seed = v.seed; cfg_stall = v.stall; cfg_bresp = v.bresp_burst;
        c_burst[0] = v.cb0; c_beat[0] = v.cbt0; c_kind[0] = v.ck0;
        c_burst[1] = v.cb1; c_beat[1] = v.cbt1; c_kind[1] = v.ck1;
        aw_cnt = 0; ar_cnt = 0; w_total = 0; w_bad = 0; addr_bad = 0; stab_bad = 0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 4000 && !done; c++) tick();
    endtask

    task automatic check_result(input vec_t v);
        check("done", done, 1);
        check("busy", busy, 0);
        check("pass", pass, v.exp_pass);
        check("err_count", err_count, v.exp_err);
        check("first_err_addr", first_err_addr, v.exp_first);
        check("aw_count", aw_cnt, v.num);
        check("ar_count", ar_cnt, v.num);
        check("w_beats", w_total, 32'(v.num) * 16);
        check("w_payload_bad", w_bad, 0);
        check("addr_ctl_bad", addr_bad, 0);
        check("stall_stability_bad", stab_bad, 0);
    endtask

    task automatic run_vec(input vec_t v);
        setup(v);
        tick();
        start = 1; base_addr = v.base; num_bursts = v.num; seed = v.seed;
        tick();
        start = 0;
        check("busy_after_start", busy, v.num != 0);
        wait_done();
        check_result(v);
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h0000_1000, 16'd1, 32'h0,         0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0,         1};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 16'd3, 32'h1234_5678, 0, -1,  2, 5, 0, -1, 0, 0, 16'd1, 32'h0000_0940, 0};
        vecs[2] = '{32'h2000_0000, 32'h2000_0000, 16'd8, 32'hDEAD_BEEF, 1, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0,         1};
        vecs[3] = '{32'h0000_3000, 32'h0000_3000, 16'd2, 32'h5,         1,  0,  0,15, 2,  1, 2, 1, 16'd3, 32'h0000_3000, 0};
        vecs[4] = '{32'h0000_4567, 32'h0000_4400, 16'd1, 32'hCAFE_F00D, 0, -1,  0, 1, 3, -1, 0, 0, 16'd1, 32'h0000_4440, 0};
        vecs[5] = '{32'hFFFF_FC00, 32'hFFFF_FC00, 16'd2, 32'h1,         0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0,         1};
        vecs[6] = '{32'h0000_8000, 32'h0000_8000, 16'd0, 32'h77,        0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0,         1};
        vecs[7] = '{32'h0010_0000, 32'h0010_0000, 16'd4, 32'h9,         1,  3,  1, 0, 1,  3,15, 0, 16'd3, 32'h0010_0C00, 0};

        // reset state
        #3;
        tag = "reset";
        check("status_and_handshakes",
              {busy, done, pass, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check("err_count", err_count, 0);
        check("first_err_addr", first_err_addr, 0);
        tick(); tick();
        #1 aresetn = 1;

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
            if (i == 0) check("beat3_word0", w_b3w0, 32'h0000_10C0);
        end

        // num=0 completes two cycles after start; a start during DONE is taken one cycle later
        tag = "done_pending_start";
        hv = '{32'h0002_0000, 32'h0002_0000, 16'd1, 32'h7, 0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0, 1};
        setup(hv);
        tick();
        start = 1; base_addr = 32'h0009_0000; num_bursts = 16'd0; seed = 32'h0;
        tick();
        check("done_at_start_plus1", {done, busy}, 2'b00);
        start = 1; base_addr = hv.base; num_bursts = hv.num; seed = hv.seed;
        tick();
        start = 0;
        check("done_pass_at_start_plus2", {done, pass, busy}, 3'b110);
        check("no_axi_traffic_empty_run", aw_cnt + ar_cnt, 0);
        tick();
        check("pending_start_taken", {busy, done}, 2'b10);
        wait_done();
        check_result(hv);

        // start while busy is dropped
        tag = "start_while_busy";
        hv = '{32'h0003_0000, 32'h0003_0000, 16'd1, 32'h3, 0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0, 1};
        setup(hv);
        tick();
        start = 1; base_addr = hv.base; num_bursts = hv.num; seed = hv.seed;
        tick();
        start = 0;
        tick(); tick();
        start = 1; base_addr = 32'h0005_0000; num_bursts = 16'd5; seed = 32'hFF;
        tick();
        start = 0;
        wait_done();
        check_result(hv);
        for (int c = 0; c < 10; c++) tick();
        check("no_restart_after_drop", {busy, done}, 2'b01);

        // asynchronous reset in the middle of a write burst
        tag = "midrun_reset";
        hv = '{32'h0006_0000, 32'h0006_0000, 16'd4, 32'h55, 0, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0, 1};
        setup(hv);
        tick();
        start = 1; base_addr = hv.base; num_bursts = hv.num; seed = hv.seed;
        tick();
        start = 0;
        for (int c = 0; c < 200 && w_total < 7; c++) tick();
        check("in_write_data", {axi.wvalid, busy}, 2'b11);
        #1 aresetn = 0;
        #1;
        check("valids_after_async_reset",
              {busy, done, pass, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        check("err_after_reset", err_count, 0);
        tick(); tick();
        aresetn = 1;
        hv = '{32'h0007_0000, 32'h0007_0000, 16'd2, 32'hA5A5_0001, 1, -1, -1, 0, 0, -1, 0, 0, 16'd0, 32'h0, 1};
        run_vec(hv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
